// File: rtl/spi2lb_pkg.sv
`default_nettype none
// spi2lb_pkg: shared FSM encoding and frame constants for the SPI-to-LocalBus bridge.
package spi2lb_pkg;

    localparam int CTRL_W      = 8;
    localparam int CTRL_WR_BIT = 7;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        CTRL   = 3'd2,
        WDATA  = 3'd3,
        WR_BUS = 3'd4,
        RD_BUS = 3'd5,
        RDATA  = 3'd6,
        DONE   = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi2lb_sync.sv
`default_nettype none
// spi2lb_sync: N-FF synchroniser for one asynchronous input, plus one extra
// stage so that single-cycle rise/fall pulses can be produced.
module spi2lb_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES:0] pipe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe <= {(STAGES+1){RST_VAL}};
        end else begin
            pipe <= {pipe[STAGES-1:0], din};
        end
    end

    assign sync = pipe[STAGES-1];
    assign rise = pipe[STAGES-1] & ~pipe[STAGES];
    assign fall = ~pipe[STAGES-1] & pipe[STAGES];

endmodule
`default_nettype wire

// File: rtl/spi2lb.sv
`default_nettype none
// spi2lb: SPI mode-0 slave turning address/control/data frames into LocalBus accesses.
// Define SPI2LB_MISO_OE_EN to add spi_miso_oe for an external tristate buffer.
module spi2lb
    import spi2lb_pkg::*;
#(
    parameter  int ADDR_W = 8,
    parameter  int DATA_W = 8,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
`ifdef SPI2LB_MISO_OE_EN
    output logic              spi_miso_oe,
`endif
    output logic [ADDR_W-1:0] lb_waddr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic [STRB_W-1:0] lb_wstrb,
    output logic              lb_wen,
    input  logic              lb_wready,
    output logic [ADDR_W-1:0] lb_raddr,
    output logic              lb_ren,
    input  logic [DATA_W-1:0] lb_rdata,
    input  logic              lb_rvalid
);

    localparam logic [5:0] ADDR_LAST = 6'(ADDR_W - 1);
    localparam logic [5:0] CTRL_LAST = 6'(CTRL_W - 1);
    localparam logic [5:0] DATA_LAST = 6'(DATA_W - 1);

    state_t state, next_state;

    logic              sck_s, sck_rise, sck_fall;
    logic              cs_n_s, cs_rise, cs_fall;
    logic              mosi_s, mosi_rise, mosi_fall;
    logic [5:0]        bit_cnt;
    logic [ADDR_W-1:0] addr;
    logic [CTRL_W-1:0] ctrl;
    logic [CTRL_W-1:0] ctrl_nx;
    logic [DATA_W-1:0] shreg;
    logic              cs_lost;
    logic              unused_bits;

    spi2lb_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst(rst), .din(spi_sck),  .sync(sck_s),  .rise(sck_rise),  .fall(sck_fall)
    );
    spi2lb_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .din(spi_cs_n), .sync(cs_n_s), .rise(cs_rise),   .fall(cs_fall)
    );
    spi2lb_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(spi_mosi), .sync(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_bits = ^{sck_s, cs_rise, cs_fall, mosi_rise, mosi_fall, ctrl[CTRL_W-2:STRB_W]};
    assign ctrl_nx     = {ctrl[CTRL_W-2:0], mosi_s};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:   if (!cs_n_s) next_state = ADDR;
            ADDR:   if (cs_n_s) next_state = IDLE;
                    else if (sck_rise && bit_cnt == ADDR_LAST) next_state = CTRL;
            CTRL:   if (cs_n_s) next_state = IDLE;
                    else if (sck_rise && bit_cnt == CTRL_LAST)
                        next_state = ctrl_nx[CTRL_WR_BIT] ? WDATA : RD_BUS;
            WDATA:  if (cs_n_s) next_state = IDLE;
                    else if (sck_rise && bit_cnt == DATA_LAST) next_state = WR_BUS;
            // A bus request is always completed; a chip-select bounce during it
            // parks the bridge in DONE until the master deselects again.
            WR_BUS: if (lb_wready) next_state = cs_n_s ? IDLE : DONE;
            RD_BUS: if (lb_rvalid) next_state = cs_n_s ? IDLE : (cs_lost ? DONE : RDATA);
            RDATA:  if (cs_n_s) next_state = IDLE;
                    else if (sck_rise && bit_cnt == DATA_LAST) next_state = DONE;
            DONE:   if (cs_n_s) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
            addr    <= '0;
            ctrl    <= '0;
            shreg   <= '0;
            cs_lost <= 1'b0;
        end else begin
            cs_lost <= (state == RD_BUS) && (cs_lost || cs_n_s);
            if (next_state != state) begin
                bit_cnt <= '0;
            end else if (sck_rise && (state == ADDR || state == CTRL ||
                                      state == WDATA || state == RDATA)) begin
                bit_cnt <= bit_cnt + 6'd1;
            end
            case (state)
                ADDR:   if (sck_rise) addr <= {addr[ADDR_W-2:0], mosi_s};
                CTRL:   if (sck_rise) ctrl <= ctrl_nx;
                WDATA:  if (sck_rise) shreg <= {shreg[DATA_W-2:0], mosi_s};
                RD_BUS: if (lb_rvalid) shreg <= lb_rdata;
                // Falls before the first data rise belong to the control phase gap.
                RDATA:  if (sck_fall && bit_cnt != 6'd0) shreg <= {shreg[DATA_W-2:0], 1'b0};
                default: ;
            endcase
        end
    end

    always_comb begin
        lb_wen   = (state == WR_BUS);
        lb_ren   = (state == RD_BUS);
        spi_miso = (state == RDATA) & shreg[DATA_W-1];
`ifdef SPI2LB_MISO_OE_EN
        spi_miso_oe = (state == RDATA);
`endif
    end

    assign lb_waddr = addr;
    assign lb_raddr = addr;
    assign lb_wdata = shreg;
    assign lb_wstrb = ctrl[STRB_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_spi2lb.sv
`default_nettype none
// tb_spi2lb: drives SPI frames at a 16-clk SCK period, emulates the LocalBus
// register target and checks every transaction against a byte-level memory model.
module tb_spi2lb;
    import spi2lb_pkg::*;

    localparam int HALF_NS = 80;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
    logic        spi_miso;
    logic [7:0]  lb_waddr, lb_raddr;
    logic [31:0] lb_wdata;
    logic [3:0]  lb_wstrb;
    logic        lb_wen, lb_ren;
    logic        lb_wready = 1'b0;
    logic        lb_rvalid = 1'b0;
    logic [31:0] lb_rdata  = 32'h0;
`ifdef SPI2LB_MISO_OE_EN
    logic        spi_miso_oe;
`endif

    always #5 clk = ~clk;

    spi2lb #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
`ifdef SPI2LB_MISO_OE_EN
        .spi_miso_oe(spi_miso_oe),
`endif
        .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_wstrb(lb_wstrb), .lb_wen(lb_wen),
        .lb_wready(lb_wready), .lb_raddr(lb_raddr), .lb_ren(lb_ren),
        .lb_rdata(lb_rdata), .lb_rvalid(lb_rvalid)
    );

    int vectors = 0, miscompares = 0;

    logic [31:0] ref_mem [256];
    logic [31:0] dev_mem [256];

    int          wr_delay = 0;
    int          wcnt = 0, rcnt = 0;
    int          wen_cycles, wen_events, ren_cycles, ren_events, unstable, oe_cycles, miso_bad;
    logic        wen_prev = 1'b0, ren_prev = 1'b0;
    logic [7:0]  cap_waddr, cap_raddr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wen_cycles = 0; wen_events = 0; ren_cycles = 0; ren_events = 0;
        unstable = 0; oe_cycles = 0; miso_bad = 0;
    endtask

    // LocalBus target: configurable write back-pressure, read data two cycles after ren.
    always @(negedge clk) begin
        if (lb_wen) begin
            if (!wen_prev) begin
                wen_events++;
                cap_waddr = lb_waddr; cap_wdata = lb_wdata; cap_wstrb = lb_wstrb;
            end else if ({lb_waddr, lb_wdata, lb_wstrb} !== {cap_waddr, cap_wdata, cap_wstrb}) begin
                unstable++;
            end
            wen_cycles++;
            wcnt++;
            lb_wready = (wcnt > wr_delay);
            if (lb_wready) begin
                for (int b = 0; b < 4; b++)
                    if (lb_wstrb[b]) dev_mem[lb_waddr][8*b +: 8] = lb_wdata[8*b +: 8];
            end
        end else begin
            wcnt = 0;
            lb_wready = (wr_delay == 0);
        end
        if (lb_ren) begin
            if (!ren_prev) begin
                ren_events++;
                cap_raddr = lb_raddr;
            end
            ren_cycles++;
            rcnt++;
            lb_rvalid = (rcnt >= 2);
            lb_rdata  = lb_rvalid ? dev_mem[lb_raddr] : $urandom;
        end else begin
            rcnt = 0;
            lb_rvalid = 1'b0;
        end
`ifdef SPI2LB_MISO_OE_EN
        if (spi_miso_oe) oe_cycles++;
        if (!spi_miso_oe && spi_miso) miso_bad++;
`endif
        wen_prev = lb_wen;
        ren_prev = lb_ren;
    end

    // Mode-0 master: mosi changes while sck is low, miso sampled at each rise.
    // Reads get two SCK periods between the last control rise and the first data rise.
    task automatic spi_xfer(input logic [7:0] a, input logic [7:0] c, input logic [31:0] d,
                            input int max_bits, output logic [31:0] rd);
        logic [47:0] f;
        f  = {a, c, d};
        rd = '0;
        spi_cs_n = 1'b0;
        for (int i = 0; i < 48 && i < max_bits; i++) begin
            if (i == 16 && !c[7]) #(2*HALF_NS);
            spi_mosi = (i >= 16 && !c[7]) ? 1'b0 : f[47-i];
            #(HALF_NS);
            if (i >= 16) rd = {rd[30:0], spi_miso};
            spi_sck = 1'b1;
            #(HALF_NS);
            spi_sck = 1'b0;
        end
        #(HALF_NS);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
    endtask

    task automatic settle();
        int t = 0;
        while ((lb_wen || lb_ren) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("bus_idle_timeout", 32'(t < 500), 32'd1);
        repeat (20) @(negedge clk);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int dly);
        logic [31:0] rd;
        clear_mon();
        wr_delay = dly;
        spi_xfer(a, {1'b1, 3'b000, s}, d, 48, rd);
        settle();
        check("wr_events",   32'(wen_events), 32'd1);
        check("wr_cycles",   32'(wen_cycles), 32'(dly + 1));
        check("wr_no_ren",   32'(ren_cycles), 32'd0);
        check("wr_addr",     32'(cap_waddr),  32'(a));
        check("wr_data",     cap_wdata,       d);
        check("wr_strb",     32'(cap_wstrb),  32'(s));
        check("wr_stable",   32'(unstable),   32'd0);
`ifdef SPI2LB_MISO_OE_EN
        check("wr_oe_low",   32'(oe_cycles),  32'd0);
`endif
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        wr_delay = 0;
    endtask

    task automatic do_read(input logic [7:0] a);
        logic [31:0] rd;
        clear_mon();
        spi_xfer(a, 8'h00, 32'h0, 48, rd);
        settle();
        check("rd_data",     rd,              ref_mem[a]);
        check("rd_events",   32'(ren_events), 32'd1);
        check("rd_cycles",   32'(ren_cycles), 32'd2);
        check("rd_addr",     32'(cap_raddr),  32'(a));
        check("rd_no_wen",   32'(wen_cycles), 32'd0);
        check("rd_miso_idle", 32'(spi_miso),  32'd0);
`ifdef SPI2LB_MISO_OE_EN
        check("rd_oe_seen",  32'(oe_cycles > 0), 32'd1);
        check("rd_miso_gated", 32'(miso_bad), 32'd0);
        check("rd_oe_after", 32'(spi_miso_oe), 32'd0);
`endif
    endtask

    initial begin
        logic [31:0] rd, v;
        int t;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            ref_mem[i] = v;
            dev_mem[i] = v;
        end
        ref_mem[8] = 32'hCAFE0001;
        dev_mem[8] = 32'hCAFE0001;

        #23;
        check("rst_wen",   32'(lb_wen),   32'd0);
        check("rst_ren",   32'(lb_ren),   32'd0);
        check("rst_miso",  32'(spi_miso), 32'd0);
        check("rst_bus",   {lb_waddr, lb_raddr, lb_wstrb, 12'h0}, 32'h0);
        check("rst_wdata", lb_wdata,      32'h0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        #20 rst = 1'b1;
        repeat (10) @(negedge clk);

        do_write(8'h04, 32'hDEADBEEF, 4'hF, 0);
        do_read(8'h08);
        do_write(8'h0C, $urandom, 4'h5, 5);
        do_read(8'h0C);

        // SCK activity while deselected must be ignored.
        clear_mon();
        for (int i = 0; i < 10; i++) begin
            spi_mosi = 1'($urandom);
            #(HALF_NS) spi_sck = 1'b1;
            #(HALF_NS) spi_sck = 1'b0;
        end
        repeat (20) @(negedge clk);
        check("cs_high_no_bus", 32'(wen_cycles + ren_cycles), 32'd0);
        check("cs_high_state",  32'(dut.state), 32'(IDLE));

        // Aborted write after 12 rises, then a full write to 0x10.
        clear_mon();
        spi_xfer(8'h10, 8'h8F, 32'h12345678, 12, rd);
        repeat (40) @(negedge clk);
        check("abort_no_bus", 32'(wen_cycles + ren_cycles), 32'd0);
        check("abort_state",  32'(dut.state), 32'(IDLE));
        do_write(8'h10, 32'hA5A55A5A, 4'hF, 0);
        do_read(8'h10);

        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(8'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 6));
            else
                do_read(8'($urandom_range(0, 15)));
        end

        // Reset while a write is stalled on the bus.
        clear_mon();
        wr_delay = 1000;
        spi_xfer(8'h20, 8'h8F, $urandom, 48, rd);
        t = 0;
        while (!lb_wen && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("stall_wen_seen", 32'(lb_wen), 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_wen",   32'(lb_wen), 32'd0);
        check("async_rst_addr",  32'(lb_waddr), 32'd0);
        check("async_rst_state", 32'(dut.state), 32'(IDLE));
        #20 rst = 1'b1;
        wr_delay = 0;
        repeat (10) @(negedge clk);
        do_read(8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20ms;
        $fatal(1, "FAIL global_timeout: simulation did not complete");
    end

endmodule
`default_nettype wire
